// File: rtl/fetch_unit_if.sv
// Signal bundle around the fetch unit: instruction-memory request/response,
// pipeline redirect, and the decoded-instruction handshake toward control.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        is_alu_reg;
  logic        is_alu_imm;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic        is_lui;
  logic        is_auipc;
  logic        is_load;
  logic        is_store;
  logic        is_system;
  logic        is_illegal;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output out_valid, out_pc, out_instr,
    output is_alu_reg, is_alu_imm, is_branch, is_jal, is_jalr, is_lui,
    output is_auipc, is_load, is_store, is_system, is_illegal,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  out_valid, out_pc, out_instr,
    input  is_alu_reg, is_alu_imm, is_branch, is_jal, is_jalr, is_lui,
    input  is_auipc, is_load, is_store, is_system, is_illegal,
    output out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one memory request in flight,
// buffers decoded words in a small FIFO and supports redirect with flush.
//
// state  | meaning
// S_IDLE | no request outstanding; may issue when buffer has room
// S_WAIT | one request outstanding; its response will be enqueued
// S_DROP | one request outstanding from before a redirect; response discarded
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam int F_ALU_REG = 0;
  localparam int F_ALU_IMM = 1;
  localparam int F_BRANCH  = 2;
  localparam int F_JAL     = 3;
  localparam int F_JALR    = 4;
  localparam int F_LUI     = 5;
  localparam int F_AUIPC   = 6;
  localparam int F_LOAD    = 7;
  localparam int F_STORE   = 8;
  localparam int F_SYSTEM  = 9;
  localparam int F_ILLEGAL = 10;
  localparam int NF        = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic          run;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [NF-1:0] flag_mem  [DEPTH];

  logic          can_issue;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          head_valid;
  logic [NF-1:0] head_flags;

  function automatic logic [NF-1:0] decode(input logic [31:0] instr);
    logic [NF-1:0] f;
    f = '0;
    case (instr[6:0])
      7'b0110011: f[F_ALU_REG] = 1'b1;
      7'b0010011: f[F_ALU_IMM] = 1'b1;
      7'b1100011: f[F_BRANCH]  = 1'b1;
      7'b1101111: f[F_JAL]     = 1'b1;
      7'b1100111: begin
        if (instr[14:12] == 3'b000) f[F_JALR] = 1'b1;
        else                        f[F_ILLEGAL] = 1'b1;
      end
      7'b0110111: f[F_LUI]     = 1'b1;
      7'b0010111: f[F_AUIPC]   = 1'b1;
      7'b0000011: f[F_LOAD]    = 1'b1;
      7'b0100011: f[F_STORE]   = 1'b1;
      7'b1110011: f[F_SYSTEM]  = 1'b1;
      default:    f[F_ILLEGAL] = 1'b1;
    endcase
    return f;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Redirect never aborts the outstanding request on the bus; it only turns
  // the pending response into one that must be thrown away.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_fire) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid)      state_nxt = S_IDLE;
        else if (bus.redirect_valid) state_nxt = S_DROP;
      end
      S_DROP: begin
        if (bus.imem_rsp_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    can_issue  = run && (state == S_IDLE) && (count < DEPTH_C) && !bus.redirect_valid;
    req_fire   = can_issue && bus.imem_req_ready;
    push       = bus.imem_rsp_valid && (state == S_WAIT) && !bus.redirect_valid;
    head_valid = (count != '0);
    pop        = head_valid && bus.out_ready && !bus.redirect_valid;

    bus.imem_req_valid = can_issue;
    bus.imem_req_addr  = fetch_pc;
    bus.out_valid      = head_valid;
    bus.out_pc         = head_valid ? pc_mem[rd_ptr]    : '0;
    bus.out_instr      = head_valid ? instr_mem[rd_ptr] : '0;
    head_flags         = head_valid ? flag_mem[rd_ptr]  : '0;
  end

  assign bus.is_alu_reg = head_flags[F_ALU_REG];
  assign bus.is_alu_imm = head_flags[F_ALU_IMM];
  assign bus.is_branch  = head_flags[F_BRANCH];
  assign bus.is_jal     = head_flags[F_JAL];
  assign bus.is_jalr    = head_flags[F_JALR];
  assign bus.is_lui     = head_flags[F_LUI];
  assign bus.is_auipc   = head_flags[F_AUIPC];
  assign bus.is_load    = head_flags[F_LOAD];
  assign bus.is_store   = head_flags[F_STORE];
  assign bus.is_system  = head_flags[F_SYSTEM];
  assign bus.is_illegal = head_flags[F_ILLEGAL];

  // run holds issue off until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      run <= 1'b1;
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (req_fire) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Entry storage needs no reset: it is only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= req_pc;
      instr_mem[wr_ptr] <= bus.imem_rsp_data;
      flag_mem[wr_ptr]  <= decode(bus.imem_rsp_data);
    end
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Owns the PC and issues word fetches to instruction memory over a valid/ready request channel. Accepts variable-latency responses and buffers fetched words in a DEPTH-entry FIFO.
- Presents {pc, instr, one-hot opcode-class flags} to decode/control through a valid/ready output handshake.
- Supports pipeline redirect (branch/jump) with flush and discard of in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
DEPTH, 2, instruction buffer entries (power of two, >=2).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request.
imem_req_addr  out  32  fetch address, word aligned.
imem_rsp_valid  in  1  response data valid (one per accepted request, in order).
imem_rsp_data  in  32  fetched instruction word.
redirect_valid  in  1  redirect PC (taken branch/jump).
redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
out_valid  out  1  buffer head valid.
out_ready  in  1  downstream consumes head.
out_pc  out  32  PC of head instruction.
out_instr  out  32  head instruction word.
is_alu_reg, is_alu_imm, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_load, is_store, is_system  out  1 each  opcode-class flags of head.
is_illegal  out  1  head opcode not recognised.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc=RESET_PC, buffer empty, no outstanding request, drop flag clear.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0, all flags 0.
- Outstanding limit and request issue:
  - At most one outstanding request.
  - imem_req_valid=1 when: not in reset, no outstanding request, (count + outstanding) < DEPTH, and redirect_valid=0.
  - imem_req_addr=fetch_pc.
  - Once asserted, valid and addr hold until the handshake, except when redirect_valid forces valid low.
- Request handshake (valid&&ready): req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0), outstanding<=1.
  - Next request is possible the cycle after the response arrives.
- Response: imem_rsp_valid with outstanding=1 clears outstanding.
  - Drop flag clear: push {req_pc, data, decoded flags}.
  - Drop flag set: discard and clear the drop flag.
  - imem_rsp_valid with outstanding=0 is ignored.
- Decode at push, registered in the buffer entry, by opcode=instr[6:0]:
  - 0110011 alu_reg; 0010011 alu_imm; 1100011 branch; 1101111 jal.
  - 1100111 jalr only if instr[14:12]=000, otherwise illegal.
  - 0110111 lui; 0010111 auipc; 0000011 load; 0100011 store; 1110011 system.
  - Anything else: is_illegal=1. Exactly one flag is high per valid entry.
  - Flags, pc and instr read 0 when out_valid=0.
- Output: out_valid=(count!=0). Pop on out_valid&&out_ready.
  - Simultaneous push and pop are allowed at any count.
  - Overflow is impossible by the issue rule.
- Latency: request accepted in cycle N, response in cycle N+k (k>=1); out_valid is high in cycle N+k+1 if the buffer was empty.
- Redirect (redirect_valid=1), highest priority:
  - Buffer flushed next cycle (out_valid=0); any same-cycle pop or push is void.
  - fetch_pc<={redirect_pc[31:2],2'b00}.
  - If a request is outstanding and its response does not arrive this cycle, drop flag<=1.
  - A response arriving in the redirect cycle is discarded.
  - The first request to the new PC issues in the cycle after redirect deasserts, when no request is outstanding.
- Back-pressure: with out_ready=0 and a full buffer, imem_req_valid stays 0 and fetch_pc is unchanged.
- Mid-operation reset: all state cleared immediately; a pending response after release is ignored (outstanding=0).

Test Plan:
- Reset release, imem_req_ready=1, responses with 1-cycle latency returning 0x00000033, 0x00500093, out_ready=1 -> req addrs 0x0,0x4,0x8…; first out_valid with out_pc=0x0, is_alu_reg=1; next out_pc=0x4, is_alu_imm=1.
- Opcode sweep: feed each opcode class, plus 0x0000_1067 (jalr funct3=001) and 0x0000_007F -> exactly one flag set per class; the last two give is_illegal=1.
- out_ready=0 for 10 cycles -> exactly DEPTH (2) responses buffered, imem_req_valid=0 thereafter, fetch_pc=0x8. Then out_ready=1 -> pcs 0x0,0x4,0x8 in order, no loss or duplication.
- Redirect to 0x0000_0102 while a request to 0x8 is outstanding and its response arrives 3 cycles later -> response discarded, buffer empty, next req addr=0x100, first out_pc=0x100.
- Redirect in the same cycle as imem_rsp_valid and out_ready=1 with 2 entries buffered -> the response is not enqueued, out_valid=0 next cycle, no pop is reported.
- rst_n asserted mid-stream with an outstanding request, released, then a stale imem_rsp_valid -> ignored; first req addr=RESET_PC.
